lock_code_programmer: RTL and testbench

//  Writer side of the combination-lock datapath: lets the user program a new NDIG-digit code.

---
 rtl/lock_pkg.sv | 16 +
 rtl/seg7_digit.sv | 23 ++
 rtl/lock_code_programmer.sv | 113 +++++++++++
 tb/tb_lock_code_programmer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding, code geometry and active-low 7-seg glyphs (gfedcba) for the lock datapath.
package lock_pkg;
    typedef enum logic [2:0] {IDLE, ENTER, CONFIRM, DONE, ERR} state_t;
    localparam int LOCK_NDIG = 6;
    localparam int LOCK_DW = 4;
    localparam logic [LOCK_NDIG*LOCK_DW-1:0] LOCK_DEFAULT_CODE = 24'h703262;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_P = 7'b0001100;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_LO = 7'b0100011;
    localparam logic [6:0] SEG_N = 7'b0101011;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_R = 7'b0101111;
    localparam logic [6:0] SEG_O = 7'b1000000;
endpackage

// File: rtl/seg7_digit.sv
// seg7_digit: 4-bit BCD to active-low gfedcba segments; codes above 9 render blank.
module seg7_digit
    import lock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/lock_code_programmer.sv
// lock_code_programmer: enter a new code twice; commit it to code_out only when both entries agree.
module lock_code_programmer
    import lock_pkg::*;
#(
    parameter int NDIG = LOCK_NDIG,
    parameter int DW = LOCK_DW,
    parameter logic [NDIG*DW-1:0] DEFAULT_CODE = LOCK_DEFAULT_CODE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [9:0]         digit,
    input  logic               digit_valid,
    output logic [NDIG*DW-1:0] code_out,
    output logic               code_valid,
    output logic               busy,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic [6:0]         hex4,
    output logic [6:0]         hex5
);
    localparam int CW = $clog2(NDIG);
    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     mism_q, mism_d;
    logic [NDIG-1:0][DW-1:0]  shadow_q, shadow_d;
    logic [3:0]               last_q, last_d;
    logic                     last_vld_q, last_vld_d;
    logic [NDIG*DW-1:0]       code_q, code_d;
    logic                     code_valid_q, code_valid_d;
    logic [CW-1:0]            idx;
    logic                     last_cnt, dig_ok;
    logic [6:0]               last_seg;
    // Digit 0 lives in the MSBs, so entry order maps to descending slots.
    assign idx = CW'(NDIG - 1) - cnt_q;
    assign last_cnt = cnt_q == CW'(NDIG - 1);
    assign dig_ok = digit <= 10'd9;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        mism_d = mism_q;
        shadow_d = shadow_q;
        last_d = last_q;
        last_vld_d = last_vld_q;
        code_d = code_q;
        code_valid_d = 1'b0;
        if (start) begin
            state_d = ENTER;
            cnt_d = '0;
            mism_d = 1'b0;
            shadow_d = '0;
            last_vld_d = 1'b0;
        end else if (digit_valid && (state_q == ENTER || state_q == CONFIRM)) begin
            if (!dig_ok) begin
                state_d = ERR;
            end else begin
                last_d = digit[3:0];
                last_vld_d = 1'b1;
                cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
                if (state_q == ENTER) begin
                    shadow_d[idx] = digit[DW-1:0];
                    state_d = last_cnt ? CONFIRM : ENTER;
                end else begin
                    mism_d = mism_q | (shadow_q[idx] != digit[DW-1:0]);
                    if (last_cnt) begin
                        state_d = mism_d ? ERR : DONE;
                        code_d = mism_d ? code_q : shadow_q;
                        code_valid_d = !mism_d;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            mism_q <= 1'b0;
            shadow_q <= '0;
            last_q <= '0;
            last_vld_q <= 1'b0;
            code_q <= DEFAULT_CODE;
            code_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            mism_q <= mism_d;
            shadow_q <= shadow_d;
            last_q <= last_d;
            last_vld_q <= last_vld_d;
            code_q <= code_d;
            code_valid_q <= code_valid_d;
        end
    end
    seg7_digit u_seg (.bcd(last_q), .seg(last_seg));
    assign code_out = code_q;
    assign code_valid = code_valid_q;
    assign busy = state_q == ENTER || state_q == CONFIRM;
    always_comb begin
        {hex5, hex4, hex3, hex2, hex1, hex0} = {6{SEG_BLANK}};
        case (state_q)
            ENTER, CONFIRM: begin
                hex5 = state_q == ENTER ? SEG_P : SEG_C;
                hex0 = last_vld_q ? last_seg : SEG_BLANK;
            end
            DONE:    {hex3, hex2, hex1, hex0} = {SEG_D, SEG_LO, SEG_N, SEG_E};
            ERR:     {hex4, hex3, hex2, hex1, hex0} = {SEG_E, SEG_R, SEG_R, SEG_O, SEG_R};
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lock_code_programmer.sv
// tb_lock_code_programmer: directed program/confirm sequences with hand-computed code, pulse and display values.
module tb_lock_code_programmer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  digit = '0;
    logic        digit_valid = 1'b0;
    logic [23:0] code_out;
    logic        code_valid, busy;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    int          vecs = 0;
    int          errs = 0;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [41:0] ALL_BLANK = {6{BL}};
    localparam logic [41:0] DONE_DISP = {BL, BL, 7'b0100001, 7'b0100011, 7'b0101011, 7'b0000110};
    localparam logic [41:0] ERR_DISP  = {BL, 7'b0000110, 7'b0101111, 7'b0101111, 7'b1000000, 7'b0101111};
    localparam logic [6:0] P = 7'b0001100;
    localparam logic [6:0] C = 7'b1000110;

    lock_code_programmer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .digit(digit), .digit_valid(digit_valid),
        .code_out(code_out), .code_valid(code_valid), .busy(busy),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    wire [41:0] hx = {hex5, hex4, hex3, hex2, hex1, hex0};

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic put(input logic [9:0] d);
        digit = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_code", 48'(code_out), 48'h703262);
        chk("reset_hex", 48'(hx), 48'(ALL_BLANK));
        chk("reset_busy", 48'(busy), 48'd0);
        chk("reset_cv", 48'(code_valid), 48'd0);
        rst_n = 1'b1;
        tick();
        put(10'd4);
        chk("idle_ignores_digit", 48'(busy), 48'd0);
        // test 1: reset mid-ENTER
        go();
        put(10'd1);
        put(10'd2);
        chk("enter_busy", 48'(busy), 48'd1);
        chk("enter_disp", 48'(hx), 48'({P, BL, BL, BL, BL, 7'b0100100}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 48'(busy), 48'd0);
        chk("async_rst_hex", 48'(hx), 48'(ALL_BLANK));
        chk("async_rst_code", 48'(code_out), 48'h703262);
        tick();
        rst_n = 1'b1;
        // test 2: matching entries commit
        go();
        chk("start_hex0_blank", 48'(hx), 48'({P, BL, BL, BL, BL, BL}));
        for (int i = 1; i <= 6; i++) put(10'(i));
        chk("confirm_disp", 48'(hx), 48'({C, BL, BL, BL, BL, 7'b0000010}));
        for (int i = 1; i <= 5; i++) put(10'(i));
        chk("pre_commit_code", 48'(code_out), 48'h703262);
        chk("pre_commit_cv", 48'(code_valid), 48'd0);
        put(10'd6);
        chk("commit_code", 48'(code_out), 48'h123456);
        chk("commit_cv", 48'(code_valid), 48'd1);
        chk("done_disp", 48'(hx), 48'(DONE_DISP));
        chk("done_busy", 48'(busy), 48'd0);
        put(10'd3);
        chk("cv_one_cycle", 48'(code_valid), 48'd0);
        chk("done_holds", 48'(hx), 48'(DONE_DISP));
        // test 3: last confirm digit differs
        go();
        for (int i = 1; i <= 6; i++) put(10'(i));
        for (int i = 1; i <= 5; i++) put(10'(i));
        chk("no_early_err", 48'(busy), 48'd1);
        put(10'd7);
        chk("mism_err_disp", 48'(hx), 48'(ERR_DISP));
        chk("mism_code_kept", 48'(code_out), 48'h123456);
        chk("mism_cv", 48'(code_valid), 48'd0);
        // first confirm digit wrong: all six still consumed
        go();
        for (int i = 1; i <= 6; i++) put(10'(i));
        put(10'd9);
        for (int i = 2; i <= 5; i++) put(10'(i));
        chk("early_mism_busy", 48'(busy), 48'd1);
        put(10'd6);
        chk("early_mism_err", 48'(hx), 48'(ERR_DISP));
        put(10'd1);
        chk("err_holds", 48'(hx), 48'(ERR_DISP));
        // test 4: illegal digit in ENTER
        go();
        put(10'd1);
        put(10'd2);
        put(10'd12);
        chk("bad_digit_disp", 48'(hx), 48'(ERR_DISP));
        chk("bad_digit_busy", 48'(busy), 48'd0);
        // illegal digit in CONFIRM
        go();
        for (int i = 1; i <= 6; i++) put(10'(i));
        put(10'd1);
        put(10'h3FF);
        chk("bad_confirm_disp", 48'(hx), 48'(ERR_DISP));
        chk("bad_confirm_code", 48'(code_out), 48'h123456);
        // test 5: start beats a simultaneous digit
        go();
        put(10'd9);
        put(10'd9);
        put(10'd9);
        start = 1'b1;
        put(10'd5);
        start = 1'b0;
        chk("restart_busy", 48'(busy), 48'd1);
        chk("restart_disp", 48'(hx), 48'({P, BL, BL, BL, BL, BL}));
        // test 6: 12 back-to-back strobes; dropped digit must not shift the count
        put(10'd9); put(10'd8); put(10'd7); put(10'd6); put(10'd5); put(10'd0);
        put(10'd9); put(10'd8); put(10'd7); put(10'd6); put(10'd5);
        chk("b2b_11_cv", 48'(code_valid), 48'd0);
        put(10'd0);
        chk("b2b_commit_code", 48'(code_out), 48'h987650);
        chk("b2b_commit_cv", 48'(code_valid), 48'd1);
        tick();
        chk("b2b_cv_drop", 48'(code_valid), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
